// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//
// Receives a framed byte stream over a valid/ready handshake, assembles
// little-endian 32-bit words and writes them sequentially into the
// instruction memory. The core is held in reset (core_run=0) until a
// complete image with a matching XOR checksum has been loaded.
//
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, 4*N data bytes (LSB first), CHK.
// N is the 16-bit word count; CHK is the XOR of all data bytes.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   rx_data    incoming byte
//   rx_valid   rx_data is valid
//   rx_ready   loader accepts a byte this cycle
//   restart    single-cycle pulse, returns DONE/ERROR to IDLE
//   imem_we    instruction memory write strobe, one cycle per word
//   imem_addr  word-aligned byte address of the write
//   imem_wdata assembled instruction word
//   core_run   core may leave reset and execute
//   load_err   error flag, held until restart
module imem_boot_loader #(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_run,
    output logic        load_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]      byte_cnt;
    logic [ADDR_W:0] word_idx;
    logic [15:0]     len_q;
    logic [7:0]      chk;
    logic [23:0]     word_buf;

    logic            accept;
    logic [31:0]     n_now;
    logic [31:0]     max_words;
    logic            last_word;

    // rx_ready is gated by reset directly so it drops the moment reset
    // is asserted, independent of the registered state.
    assign rx_ready  = reset && (state != ST_DONE) && (state != ST_ERROR);
    assign accept    = rx_valid && rx_ready;

    // Word count as it will be once LEN_HI is latched this cycle.
    assign n_now     = {16'd0, rx_data, len_q[7:0]};
    assign max_words = 32'd1 << ADDR_W;

    // True while the word currently being assembled is the final one.
    assign last_word = (32'(word_idx) + 32'd1) == {16'd0, len_q};

    assign core_run  = (state == ST_DONE);
    assign load_err  = (state == ST_ERROR);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    if (n_now == 32'd0) begin
                        state_next = ST_CHECK;
                    end else if (n_now > max_words) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept && byte_cnt == 2'd3 && last_word) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    state_next = (rx_data == chk) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame datapath: length latch, byte assembly, checksum and the
    // registered memory write port. imem_addr/imem_wdata only change on
    // a write so they hold their last value between strobes.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            byte_cnt   <= '0;
            word_idx   <= '0;
            len_q      <= '0;
            chk        <= '0;
            word_buf   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        chk      <= '0;
                        word_idx <= '0;
                        byte_cnt <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= rx_data;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= rx_data;
                        byte_cnt    <= '0;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        chk      <= chk ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= 32'({word_idx, 2'b00});
                                imem_wdata <= {rx_data, word_buf};
                                word_idx   <= word_idx + 1'b1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//
// Self-checking bench for imem_boot_loader built with ADDR_W=2 so the
// oversize and maximum-image boundaries are cheap to reach. Frames are
// built from lists of words; the expected memory writes, checksum and
// final outcome are derived from the frame format itself.
module tb_imem_boot_loader;

    localparam int AW = 2;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        restart = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_run;
    logic        load_err;

    int total = 0;
    int bad = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_boot_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
        .CLK(CLK),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .restart(restart),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_run(core_run),
        .load_err(load_err)
    );

    always #5 CLK = ~CLK;

    // Record every write strobe seen between rising edges.
    always @(negedge CLK) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Gap cycles with rx_valid low precede the byte; the byte is then
    // held valid until the loader takes it (bounded wait).
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            check("send_timeout", {31'd0, rx_ready}, 32'd1);
        end else begin
            @(negedge CLK);
        end
        rx_valid = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle per byte, 2 random 0..2.
    task automatic send_frame(input logic [7:0] fr[$], input int gap_mode);
        int g;
        foreach (fr[i]) begin
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            send_byte(fr[i], g);
        end
    endtask

    // Frame from a word list; corrupt!=0 flips checksum bits.
    function automatic void build_frame(input logic [31:0] words[$], input logic [7:0] corrupt,
                                        output logic [7:0] fr[$]);
        logic [7:0]  x;
        logic [15:0] n;
        x = 8'h00;
        n = 16'(words.size());
        fr = {};
        fr.push_back(8'hA5);
        fr.push_back(n[7:0]);
        fr.push_back(n[15:8]);
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                fr.push_back(words[i][8*k +: 8]);
                x = x ^ words[i][8*k +: 8];
            end
        end
        fr.push_back(x ^ corrupt);
    endfunction

    task automatic check_writes(input string tag, input logic [31:0] words[$]);
        check({tag, "_count"}, 32'(wr_addr.size()), 32'(words.size()));
        if (wr_addr.size() == words.size()) begin
            foreach (words[i]) begin
                check({tag, "_addr"}, wr_addr[i], 32'(i * 4));
                check({tag, "_data"}, wr_data[i], words[i]);
            end
        end
        wr_addr = {};
        wr_data = {};
    endtask

    task automatic pulse_restart();
        @(negedge CLK);
        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
    endtask

    initial begin
        logic [31:0] words[$];
        logic [31:0] none[$];
        logic [7:0]  fr[$];
        logic [7:0]  garbage;
        logic [7:0]  corrupt;
        int          n;

        none = {};

        // Reset state
        #1;
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_run", {31'd0, core_run}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check("idle_ready", {31'd0, rx_ready}, 32'd1);

        // Basic two-word load
        words = '{32'h00000013, 32'h00100093};
        build_frame(words, 8'h00, fr);
        send_frame(fr, 0);
        check_writes("basic", words);
        check("basic_run", {31'd0, core_run}, 32'd1);
        check("basic_err", {31'd0, load_err}, 32'd0);
        check("basic_ready", {31'd0, rx_ready}, 32'd0);
        pulse_restart();
        check("basic_rst_run", {31'd0, core_run}, 32'd0);
        check("basic_rst_ready", {31'd0, rx_ready}, 32'd1);

        // Checksum mismatch: writes still happen, then ERROR
        fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
        send_frame(fr, 0);
        check_writes("badchk", words);
        check("badchk_err", {31'd0, load_err}, 32'd1);
        check("badchk_run", {31'd0, core_run}, 32'd0);
        check("badchk_ready", {31'd0, rx_ready}, 32'd0);
        pulse_restart();
        check("badchk_rst_err", {31'd0, load_err}, 32'd0);
        check("badchk_rst_ready", {31'd0, rx_ready}, 32'd1);

        // Garbage then zero-length image
        fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 0);
        check_writes("zero", none);
        check("zero_run", {31'd0, core_run}, 32'd1);
        pulse_restart();

        // Oversize: 5 words exceeds the 4-word memory
        fr = '{8'hA5, 8'h05, 8'h00};
        send_frame(fr, 0);
        check("over_err", {31'd0, load_err}, 32'd1);
        check("over_ready", {31'd0, rx_ready}, 32'd0);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (3) @(negedge CLK);
        check("over_hold_ready", {31'd0, rx_ready}, 32'd0);
        check("over_hold_err", {31'd0, load_err}, 32'd1);
        rx_valid = 1'b0;
        check_writes("over", none);
        pulse_restart();
        check("over_rst_err", {31'd0, load_err}, 32'd0);

        // Maximum legal image: 4 words, last address 0xC
        words = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF};
        build_frame(words, 8'h00, fr);
        send_frame(fr, 0);
        check_writes("max", words);
        check("max_run", {31'd0, core_run}, 32'd1);
        pulse_restart();

        // Backpressure: rx_valid alternates every cycle
        words = '{32'h00000013, 32'h00100093};
        build_frame(words, 8'h00, fr);
        send_frame(fr, 1);
        check_writes("bp", words);
        check("bp_run", {31'd0, core_run}, 32'd1);
        check("bp_err", {31'd0, load_err}, 32'd0);
        pulse_restart();

        // Reset mid-load after the second data byte
        fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        send_frame(fr, 0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_ready", {31'd0, rx_ready}, 32'd0);
        check("mid_we", {31'd0, imem_we}, 32'd0);
        check("mid_addr", imem_addr, 32'd0);
        check("mid_wdata", imem_wdata, 32'd0);
        check("mid_run", {31'd0, core_run}, 32'd0);
        check("mid_err", {31'd0, load_err}, 32'd0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        wr_addr = {};
        wr_data = {};
        build_frame(words, 8'h00, fr);
        send_frame(fr, 0);
        check_writes("reload", words);
        check("reload_run", {31'd0, core_run}, 32'd1);
        pulse_restart();

        // Randomised frames: garbage prefix, random words, random gaps,
        // checksum corrupted about a third of the time
        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(1, 4));
            words = {};
            for (int i = 0; i < n; i++) begin
                words.push_back($urandom);
            end
            corrupt = ($urandom_range(0, 2) == 0) ? 8'(1 + $urandom_range(0, 254)) : 8'h00;
            build_frame(words, corrupt, fr);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                garbage = 8'($urandom_range(0, 255));
                if (garbage == 8'hA5) begin
                    garbage = 8'h5A;
                end
                fr.push_front(garbage);
            end
            send_frame(fr, 2);
            check_writes("rand", words);
            check("rand_run", {31'd0, core_run}, {31'd0, corrupt == 8'h00});
            check("rand_err", {31'd0, load_err}, {31'd0, corrupt != 8'h00});
            pulse_restart();
            check("rand_idle", {31'd0, rx_ready}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
